// File: rtl/err_inject_if.sv
// Bus bundle for err_inject_ctrl: configuration, control pulses, word stream and status.
// The master drives configuration and data; the slave is the controller.
interface err_inject_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [1:0]        cfg_mode;
  logic [15:0]       cfg_period;
  logic [15:0]       cfg_thresh;
  logic [BIT_W-1:0]  cfg_bit;
  logic              cfg_walk;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              err_flag;
  logic              busy;
  logic [CNT_W-1:0]  word_count;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output cfg_mode, cfg_period, cfg_thresh, cfg_bit, cfg_walk,
    output start, stop, in_valid, in_data,
    input  out_valid, out_data, err_flag, busy, word_count, err_count
  );

  modport slave (
    input  cfg_mode, cfg_period, cfg_thresh, cfg_bit, cfg_walk,
    input  start, stop, in_valid, in_data,
    output out_valid, out_data, err_flag, busy, word_count, err_count
  );
endinterface

// File: rtl/err_inject_ctrl.sv
// Error-injection controller for the BER tester transmit path: flips at most one bit
// per valid word (single, periodic or LFSR-random) and counts processed/corrupted words.
module err_inject_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  err_inject_if.slave bus
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_PER    = 2'd2;
  localparam logic [1:0] MODE_RAND   = 2'd3;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_mode;
  logic [15:0]       r_period;
  logic [15:0]       r_thresh;
  logic              r_walk;
  logic [BIT_W-1:0]  r_bitpos;
  logic [15:0]       r_pcnt;
  logic [15:0]       r_lfsr;
  logic [CNT_W-1:0]  r_word_count;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_busy;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_err_flag;

  logic              w_start;
  logic              w_decide;
  logic              w_inject;
  logic [15:0]       w_period_m1;
  logic [15:0]       w_lfsr_nxt;
  logic [DATA_W-1:0] w_mask;

  // stop dominates start; a word arriving with start is treated as IDLE traffic
  assign w_start     = bus.start & ~bus.stop;
  assign w_decide    = (r_state == ST_RUN) & bus.in_valid & ~w_start;
  assign w_period_m1 = (r_period == 16'd0) ? 16'd0 : 16'(r_period - 16'd1);
  assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_mask      = DATA_W'(1) << r_bitpos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
    end
  end

  // Next state and per-word injection decision
  always_comb begin
    w_state_nxt = r_state;
    w_inject    = 1'b0;
    if (w_decide) begin
      case (r_mode)
        MODE_SINGLE: w_inject = 1'b1;
        MODE_PER:    w_inject = (r_pcnt == w_period_m1);
        MODE_RAND:   w_inject = (r_lfsr < r_thresh);
        default:     w_inject = 1'b0;
      endcase
    end
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = (bus.cfg_mode != MODE_OFF) ? ST_RUN : ST_IDLE;
    end else if ((r_state == ST_RUN) && (r_mode == MODE_SINGLE) && w_inject) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Configuration latch, counters, period counter, LFSR and bit position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= MODE_OFF;
      r_period     <= 16'd0;
      r_thresh     <= 16'd0;
      r_walk       <= 1'b0;
      r_bitpos     <= '0;
      r_pcnt       <= 16'd0;
      r_lfsr       <= LFSR_SEED;
      r_word_count <= '0;
      r_err_count  <= '0;
    end else if (w_start) begin
      r_mode       <= bus.cfg_mode;
      r_period     <= bus.cfg_period;
      r_thresh     <= bus.cfg_thresh;
      r_walk       <= bus.cfg_walk;
      r_bitpos     <= bus.cfg_bit;
      r_pcnt       <= 16'd0;
      r_lfsr       <= LFSR_SEED;
      r_word_count <= '0;
      r_err_count  <= '0;
    end else if (w_decide) begin
      r_lfsr <= w_lfsr_nxt;
      if (r_word_count != '1) r_word_count <= r_word_count + CNT_W'(1);
      if (r_mode == MODE_PER) r_pcnt <= w_inject ? 16'd0 : 16'(r_pcnt + 16'd1);
      if (w_inject) begin
        if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
        if (r_walk) begin
          r_bitpos <= (r_bitpos == BIT_W'(DATA_W - 1)) ? '0 : r_bitpos + BIT_W'(1);
        end
      end
    end
  end

  // One-cycle registered data path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      r_out_data  <= bus.in_data ^ (w_inject ? w_mask : '0);
      r_err_flag  <= w_inject;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.err_flag   = r_err_flag;
  assign bus.busy       = r_busy;
  assign bus.word_count = r_word_count;
  assign bus.err_count  = r_err_count;

endmodule
